regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the pipelined core: 2 combinational read ports,
//  2 write ports (WB lane A, WB lane B), x0 hardwired to zero, write-to-read bypass so ID sees same-cycle
//  WB data, and a hardware clear sequencer that zeroes every entry after reset (no initial blocks/memfiles).
//  Sits between ID (reads) and WB (writes); ready gates the fetch stage until the clear completes.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; NREGS = 2**ADDR_W entries
//  BYPASS   1   1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
// PORTS
//  clk     in   1       rising-edge clock
//  rst     in   1       asynchronous, active-low reset
//  we_a    in   1       write enable, port A
//  wa_a    in   ADDR_W  write address, port A
//  wd_a    in   DATA_W  write data, port A
//  we_b    in   1       write enable, port B (younger instruction)
//  wa_b    in   ADDR_W  write address, port B
//  wd_b    in   DATA_W  write data, port B
//  ra1     in   ADDR_W  read address 1
//  ra2     in   ADDR_W  read address 2
//  rd1     out  DATA_W  read data 1 (combinational)
//  rd2     out  DATA_W  read data 2 (combinational)
//  ready   out  1       1 = clear done, file accepting writes / giving valid reads
//  wr_cnt  out  16      saturating count of committed writes (diagnostic)
// BEHAVIOUR
//  FSM states: CLEAR, RUN.
//  - rst=0 (async): state<=CLEAR, clr_idx<=1, ready<=0, wr_cnt<=0; storage contents untouched by reset itself.
//  - CLEAR: each clk writes 0 to entry clr_idx, clr_idx++; when clr_idx==NREGS-1 is written -> RUN next cycle.
//    Takes NREGS-1 cycles after rst deasserts; ready rises on cycle NREGS-1 (31 for ADDR_W=5).
//  - CLEAR: we_a/we_b ignored (not stored, not counted); rd1/rd2 forced to 0.
//  - RUN: ready=1; on clk, we_a & wa_a!=0 stores wd_a; we_b & wa_b!=0 stores wd_b.
//  - Both ports same nonzero address same cycle: port B value stored (B is younger).
//  - Writes to address 0 always discarded; reads of address 0 always return 0.
//  - Read (RUN): rd = 0 if ra==0; else if BYPASS & we_b & wa_b==ra -> wd_b;
//    else if BYPASS & we_a & wa_a==ra -> wd_a; else stored entry. Zero-cycle latency.
//  - Write latency: value visible via storage on cycle after the write edge (earlier only through bypass).
//  - wr_cnt: +1 per port that commits a write in RUN (0, 1 or 2 per cycle); saturates at 16'hFFFF.
//    Same-address dual write counts 2. Address-0 writes do not count.
//  - rst asserted mid-CLEAR or mid-RUN: immediate return to CLEAR, clear restarts from entry 1.
// TESTING
//  1. Reset release: rst 0->1, no writes -> ready=0 for 31 cycles, 1 on cycle 31; all 31 entries read 0.
//  2. Write/read: RUN, we_a=1 wa_a=5 wd_a=32'hDEADBEEF -> next cycle ra1=5 gives DEADBEEF; wr_cnt=1.
//  3. Bypass: we_b=1 wa_b=7 wd_b=32'h1234, ra2=7 same cycle -> rd2=32'h1234 combinationally;
//     BYPASS=0 build -> rd2=old value (0).
//  4. Conflict + x0: we_a,we_b both addr 9 (A=11, B=22) -> entry 9=22, wr_cnt+=2; write 32'hFFFF to
//     addr 0 -> rd=0, wr_cnt unchanged.
//  5. Writes during CLEAR: we_a=1 wa_a=3 wd_a=5 in cycle 2 of clear -> entry 3 reads 0 after ready; wr_cnt=0.
//  6. Reset mid-op: rst pulsed low for 1 cycle while ready=1 with regs populated -> ready=0 for 31 cycles,
//     then all regs 0; wr_cnt=0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with x0, write bypass and post-reset clear sequencer
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              ready,
    output logic [15:0]       wr_cnt
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] mem_q [NREGS];

    logic        running;
    logic        commit_a, commit_b;
    logic [1:0]  inc;
    logic [16:0] cnt_sum;

    assign running  = (state_q == RUN);
    assign commit_a = running && we_a && (wa_a != '0);
    assign commit_b = running && we_b && (wa_b != '0);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        inc      = 2'(commit_a) + 2'(commit_b);
        cnt_sum  = 17'(wr_cnt_q) + 17'(inc);
        wr_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= ADDR_W'(1);
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Storage is deliberately outside the reset domain; the clear sequencer zeroes it.
    // Port B is written last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            if (commit_a) mem_q[wa_a] <= wd_a;
            if (commit_b) mem_q[wa_b] <= wd_b;
        end
    end

    function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] ra,
                                                   input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] val;
        val = stored;
        if (!running || ra == '0)                  val = '0;
        else if (BYPASS && we_b && wa_b == ra)     val = wd_b;
        else if (BYPASS && we_a && wa_a == ra)     val = wd_a;
        return val;
    endfunction

    assign rd1    = read_sel(ra1, mem_q[ra1]);
    assign rd2    = read_sel(ra2, mem_q[ra2]);
    assign ready  = running;
    assign wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass builds)
module tb_regfile_mp;
    logic        clk, rst;
    logic        we_a, we_b;
    logic [4:0]  wa_a, wa_b, ra1, ra2;
    logic [31:0] wd_a, wd_b;
    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        ready, nb_ready;
    logic [15:0] wr_cnt, nb_wr_cnt;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .ready(ready), .wr_cnt(wr_cnt));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .ra1(ra1), .ra2(ra2),
        .rd1(nb_rd1), .rd2(nb_rd2), .ready(nb_ready), .wr_cnt(nb_wr_cnt));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the file is all-zero once 31 clock edges have passed since reset release;
    // until then reads are zero and writes are dropped.
    int          m_cyc;
    int          m_cnt;
    logic [31:0] m_mem [32];

    always @(posedge clk) begin
        int n;
        if (!rst) begin
            m_cyc = 0;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = 0;
        end else if (m_cyc < 31) begin
            m_cyc++;
        end else begin
            n = 0;
            if (we_a && wa_a != 0) begin m_mem[wa_a] = wd_a; n++; end
            if (we_b && wa_b != 0) begin m_mem[wa_b] = wd_b; n++; end
            m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (!rst || m_cyc < 31 || ra == 0) return 32'd0;
        if (byp && we_b && wa_b == ra) return wd_b;
        if (byp && we_a && wa_a == ra) return wd_a;
        return m_mem[ra];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("rd1",       rd1,       exp_rd(ra1, 1'b1));
            chk("rd2",       rd2,       exp_rd(ra2, 1'b1));
            chk("nb_rd1",    nb_rd1,    exp_rd(ra1, 1'b0));
            chk("nb_rd2",    nb_rd2,    exp_rd(ra2, 1'b0));
            chk("ready",     ready,     (rst && m_cyc >= 31));
            chk("wr_cnt",    wr_cnt,    rst ? m_cnt : 0);
            chk("nb_wr_cnt", nb_wr_cnt, rst ? m_cnt : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
    endtask

    initial begin
        int n;
        rst = 0; ra1 = 0; ra2 = 0;
        idle();
        repeat (3) step();
        check_en = 1;
        chk("reset_ready", ready, 0);
        chk("reset_wr_cnt", wr_cnt, 0);

        // Reset release and clear duration
        rst = 1;
        n = 0;
        while (!ready && n < 100) begin step(); n++; end
        chk("clear_latency", n, 31);
        for (int i = 1; i < 32; i += 2) begin
            ra1 = 5'(i); ra2 = 5'(i + 1);
            #1;
            chk("cleared_rd1", rd1, 0);
            chk("cleared_rd2", rd2, 0);
            step();
        end

        // Write then read back through storage
        we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
        step();
        idle(); ra1 = 5;
        #1;
        chk("wr_rd_5", rd1, 32'hDEADBEEF);
        chk("wr_cnt_1", wr_cnt, 1);

        // Same-cycle bypass vs no-bypass build
        we_b = 1; wa_b = 7; wd_b = 32'h1234; ra2 = 7;
        #1;
        chk("bypass_rd2", rd2, 32'h1234);
        chk("nobypass_rd2", nb_rd2, 0);
        step();
        idle();

        // Dual write to one address: B wins, counts 2; bypass prefers B too
        we_a = 1; wa_a = 9; wd_a = 11; we_b = 1; wa_b = 9; wd_b = 22; ra1 = 9;
        #1;
        chk("bypass_conflict", rd1, 22);
        step();
        idle(); ra1 = 9;
        #1;
        chk("conflict_rd", rd1, 22);
        chk("conflict_cnt", wr_cnt, 4);

        // x0 writes discarded and not counted
        we_a = 1; wa_a = 0; wd_a = 32'hFFFF; ra1 = 0;
        #1;
        chk("x0_bypass", rd1, 0);
        step();
        idle();
        #1;
        chk("x0_rd", rd1, 0);
        chk("x0_cnt", wr_cnt, 4);

        // Random dual writes long enough to saturate the counter
        for (int i = 0; i < 32800; i++) begin
            we_a = 1; wa_a = 5'($urandom_range(1, 31)); wd_a = $urandom;
            we_b = 1; wa_b = 5'($urandom_range(1, 31)); wd_b = $urandom;
            ra1 = 5'($urandom_range(0, 31)); ra2 = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        #1;
        chk("wr_cnt_sat", wr_cnt, 16'hFFFF);

        // Reset mid-run with writes attempted during the clear
        rst = 0;
        #1;
        chk("async_ready", ready, 0);
        chk("async_cnt", wr_cnt, 0);
        step();
        rst = 1;
        n = 0;
        step(); n++;
        we_a = 1; wa_a = 3; wd_a = 5;
        step(); n++;
        idle();
        while (!ready && n < 100) begin step(); n++; end
        chk("reclear_latency", n, 31);
        ra1 = 3; ra2 = 9;
        #1;
        chk("clear_write_dropped", rd1, 0);
        chk("reclear_rd9", rd2, 0);
        chk("reclear_cnt", wr_cnt, 0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            step();
        end

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
